// File: rtl/mdu_sched_pkg.sv
// Shared opcode, state and latency definitions for the multiply/divide scheduler.
package mdu_sched_pkg;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  // Only these four occupy the unit; all other codes complete in E or are NONE.
  function automatic logic isArithOp(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic isDivOp(input logic [3:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/mdu_sched_if.sv
// E/D-stage handshake and HI/LO result bus between the pipeline and the MD scheduler.
interface mdu_sched_if;

  logic        e_valid;
  logic [3:0]  e_op;
  logic [31:0] e_a;
  logic [31:0] e_b;
  logic        d_is_md;
  logic        start;
  logic        busy;
  logic        md_stall;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic [31:0] e_rd_data;

  modport slave (
    input  e_valid, e_op, e_a, e_b, d_is_md,
    output start, busy, md_stall, hi_o, lo_o, e_rd_data
  );

  modport master (
    output e_valid, e_op, e_a, e_b, d_is_md,
    input  start, busy, md_stall, hi_o, lo_o, e_rd_data
  );

endinterface

// File: rtl/mdu_sched_arith.sv
// Combinational HI/LO result generator; divide-by-zero passes the current HI/LO through.
module mdu_arith
  import mdu_sched_pkg::*;
(
  input  logic [3:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [31:0] cur_hi_i,
  input  logic [31:0] cur_lo_i,
  output logic [31:0] res_hi_o,
  output logic [31:0] res_lo_o
);

  logic [63:0] sProd;
  logic [63:0] uProd;
  logic [31:0] aMag;
  logic [31:0] bMag;
  logic [31:0] magQuot;
  logic [31:0] magRem;
  logic [31:0] sQuot;
  logic [31:0] sRem;
  logic [31:0] uQuot;
  logic [31:0] uRem;
  logic        bZero;

  assign sProd = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
  assign uProd = {32'd0, a_i} * {32'd0, b_i};

  // Signed divide on magnitudes: 0x80000000 keeps its bit pattern, so /-1 yields 0x80000000 rem 0.
  assign aMag    = a_i[31] ? (32'd0 - a_i) : a_i;
  assign bMag    = b_i[31] ? (32'd0 - b_i) : b_i;
  assign bZero   = (b_i == 32'd0);
  assign magQuot = bZero ? 32'd0 : (aMag / bMag);
  assign magRem  = bZero ? 32'd0 : (aMag % bMag);
  assign sQuot   = (a_i[31] ^ b_i[31]) ? (32'd0 - magQuot) : magQuot;
  assign sRem    = a_i[31] ? (32'd0 - magRem) : magRem;
  assign uQuot   = bZero ? 32'd0 : (a_i / b_i);
  assign uRem    = bZero ? 32'd0 : (a_i % b_i);

  always_comb begin
    res_hi_o = cur_hi_i;
    res_lo_o = cur_lo_i;
    case (op_i)
      MD_MULT: begin
        res_hi_o = sProd[63:32];
        res_lo_o = sProd[31:0];
      end
      MD_MULTU: begin
        res_hi_o = uProd[63:32];
        res_lo_o = uProd[31:0];
      end
      MD_DIV: begin
        if (!bZero) begin
          res_hi_o = sRem;
          res_lo_o = sQuot;
        end
      end
      MD_DIVU: begin
        if (!bZero) begin
          res_hi_o = uRem;
          res_lo_o = uQuot;
        end
      end
      default: begin
        res_hi_o = cur_hi_i;
        res_lo_o = cur_lo_i;
      end
    endcase
  end

endmodule

// File: rtl/mdu_sched.sv
// Multi-cycle MD scheduler: fixed-latency busy counter, HI/LO ownership and D-stage stall.
module mdu_sched
  import mdu_sched_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  mdu_sched_if.slave  bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        hi_q, hi_d;
  logic [31:0]        lo_q, lo_d;
  logic [31:0]        pendHi_q, pendHi_d;
  logic [31:0]        pendLo_q, pendLo_d;
  logic [31:0]        resHi;
  logic [31:0]        resLo;
  logic               startW;

  mdu_arith u_arith (
    .op_i     (bus.e_op),
    .a_i      (bus.e_a),
    .b_i      (bus.e_b),
    .cur_hi_i (hi_q),
    .cur_lo_i (lo_q),
    .res_hi_o (resHi),
    .res_lo_o (resLo)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      pendHi_q <= '0;
      pendLo_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      pendHi_q <= pendHi_d;
      pendLo_q <= pendLo_d;
    end
  end

  // The result is computed at start and parked; HI/LO only change on the commit edge.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    pendHi_d = pendHi_q;
    pendLo_d = pendLo_q;
    startW   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.e_valid && isArithOp(bus.e_op)) begin
          startW   = 1'b1;
          pendHi_d = resHi;
          pendLo_d = resLo;
          cnt_d    = isDivOp(bus.e_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d  = S_BUSY;
        end else if (bus.e_valid && (bus.e_op == MD_MTHI)) begin
          hi_d = bus.e_a;
        end else if (bus.e_valid && (bus.e_op == MD_MTLO)) begin
          lo_d = bus.e_a;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pendHi_q;
          lo_d    = pendLo_q;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.start     = startW;
  assign bus.busy      = (state_q == S_BUSY);
  assign bus.md_stall  = bus.d_is_md & (startW | (state_q == S_BUSY));
  assign bus.hi_o      = hi_q;
  assign bus.lo_o      = lo_q;
  assign bus.e_rd_data = (bus.e_op == MD_MFHI) ? hi_q :
                         (bus.e_op == MD_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_sched.sv
// Randomised and directed bench for mdu_sched against a cycle-count/arithmetic reference model.
module tb_mdu_sched;
  import mdu_sched_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;
  int   stallCnt;

  logic [31:0] mHi, mLo, mPendHi, mPendLo;
  int          mLeft;

  mdu_sched_if bus();

  mdu_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void modelResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] hi, output logic [31:0] lo);
    logic signed [31:0] sa32, sb32;
    longint             sa, sb, q, r;
    logic [63:0]        p;
    sa32 = a;
    sb32 = b;
    sa   = longint'(sa32);
    sb   = longint'(sb32);
    hi   = mHi;
    lo   = mLo;
    if (op == MD_MULT) begin
      p  = 64'(sa * sb);
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == MD_MULTU) begin
      p  = {32'd0, a} * {32'd0, b};
      hi = p[63:32];
      lo = p[31:0];
    end else if (op == MD_DIV && b != 0) begin
      q  = sa / sb;
      r  = sa % sb;
      lo = q[31:0];
      hi = r[31:0];
    end else if (op == MD_DIVU && b != 0) begin
      lo = a / b;
      hi = a % b;
    end
  endfunction

  function automatic void resetModel();
    mHi = 0; mLo = 0; mPendHi = 0; mPendLo = 0; mLeft = 0;
  endfunction

  // One pipeline cycle: drive E/D inputs, compare against the model, then advance the model.
  task automatic applyStimulus(input logic v, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic dmd);
    logic        expBusy, expStart, expStall, arith;
    logic [31:0] expRd;
    @(posedge clk);
    #1;
    bus.e_valid = v;
    bus.e_op    = op;
    bus.e_a     = a;
    bus.e_b     = b;
    bus.d_is_md = dmd;
    #1;
    arith    = (op >= 4'd1) && (op <= 4'd4);
    expBusy  = (mLeft > 0);
    expStart = !expBusy && v && arith;
    expStall = dmd && (expStart || expBusy);
    expRd    = (op == MD_MFHI) ? mHi : (op == MD_MFLO) ? mLo : 32'd0;
    checkOutput("start", 32'(bus.start), 32'(expStart));
    checkOutput("busy", 32'(bus.busy), 32'(expBusy));
    checkOutput("md_stall", 32'(bus.md_stall), 32'(expStall));
    checkOutput("hi_o", bus.hi_o, mHi);
    checkOutput("lo_o", bus.lo_o, mLo);
    checkOutput("e_rd_data", bus.e_rd_data, expRd);
    checkOutput("proto", 32'(bus.busy && v && (op >= 4'd1) && (op <= 4'd8)), 32'd0);
    if (bus.md_stall) stallCnt++;
    if (expBusy) begin
      mLeft--;
      if (mLeft == 0) begin
        mHi = mPendHi;
        mLo = mPendLo;
      end
    end else if (expStart) begin
      modelResult(op, a, b, mPendHi, mPendLo);
      mLeft = (op == MD_DIV || op == MD_DIVU) ? DIV_N : MULT_N;
    end else if (v && op == MD_MTHI) begin
      mHi = a;
    end else if (v && op == MD_MTLO) begin
      mLo = a;
    end
  endtask

  task automatic idle(input int n, input logic dmd);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, MD_NONE, 32'd0, 32'd0, dmd);
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'($urandom_range(0, 20));
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0] op;
    checks = 0;
    errors = 0;
    stallCnt = 0;
    resetModel();
    bus.e_valid = 0; bus.e_op = 0; bus.e_a = 0; bus.e_b = 0; bus.d_is_md = 1'b1;
    reset_n = 1'b0;
    #12;
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_hi", bus.hi_o, 32'd0);
    checkOutput("rst_lo", bus.lo_o, 32'd0);
    checkOutput("rst_stall", 32'(bus.md_stall), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    applyStimulus(1'b1, MD_MULT, 32'hFFFFFFFD, 32'd5, 1'b0);
    idle(MULT_N + 1, 1'b0);
    checkOutput("mult_hi", bus.hi_o, 32'hFFFFFFFF);
    checkOutput("mult_lo", bus.lo_o, 32'hFFFFFFF1);

    applyStimulus(1'b1, MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0);
    idle(MULT_N + 1, 1'b0);
    checkOutput("multu_hi", bus.hi_o, 32'h00000001);
    checkOutput("multu_lo", bus.lo_o, 32'hFFFFFFFE);

    stallCnt = 0;
    applyStimulus(1'b1, MD_DIV, 32'hFFFFFFF9, 32'd2, 1'b1);
    idle(DIV_N + 1, 1'b1);
    checkOutput("div_stall_cycles", 32'(stallCnt), 32'd11);
    checkOutput("div_lo", bus.lo_o, 32'hFFFFFFFD);
    checkOutput("div_hi", bus.hi_o, 32'hFFFFFFFF);
    checkOutput("div_stall_after", 32'(bus.md_stall), 32'd0);

    applyStimulus(1'b1, MD_MTHI, 32'h11, 32'd0, 1'b0);
    applyStimulus(1'b1, MD_MTLO, 32'h22, 32'd0, 1'b0);
    applyStimulus(1'b1, MD_DIVU, 32'd1234, 32'd0, 1'b0);
    idle(DIV_N + 1, 1'b0);
    checkOutput("div0_hi", bus.hi_o, 32'h11);
    checkOutput("div0_lo", bus.lo_o, 32'h22);

    applyStimulus(1'b1, MD_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    idle(DIV_N + 1, 1'b0);
    checkOutput("divovf_lo", bus.lo_o, 32'h80000000);
    checkOutput("divovf_hi", bus.hi_o, 32'h0);

    applyStimulus(1'b1, MD_MTHI, 32'hABCD, 32'd0, 1'b0);
    applyStimulus(1'b1, MD_MFHI, 32'd0, 32'd0, 1'b0);
    checkOutput("mfhi_data", bus.e_rd_data, 32'h0000ABCD);

    applyStimulus(1'b1, MD_MTLO, 32'h55, 32'd0, 1'b0);
    applyStimulus(1'b1, MD_MULT, 32'd7, 32'd9, 1'b1);
    idle(3, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_busy", 32'(bus.busy), 32'd0);
    checkOutput("arst_hi", bus.hi_o, 32'd0);
    checkOutput("arst_lo", bus.lo_o, 32'd0);
    #2;
    reset_n = 1'b1;
    resetModel();
    idle(3, 1'b1);

    for (int i = 0; i < 400; i++) begin
      if (mLeft > 0) op = ($urandom_range(0, 1) == 0) ? MD_NONE : 4'($urandom_range(9, 15));
      else op = 4'($urandom_range(0, 15));
      applyStimulus(1'($urandom_range(0, 3) != 0), op, randOperand(), randOperand(),
                    1'($urandom_range(0, 1)));
    end
    idle(DIV_N + 2, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
